// File: rtl/tick_burst_pkg.sv
// Shared types and constants for the tick_burst channel generator.
package tick_burst_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/tick_burst_chan.sv
// One burst channel: IDLE/RUN state, tick down-counter and registered strobes.
module tick_burst_chan
    import tick_burst_pkg::*;
#(
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hit,
    input  logic                start,
    input  logic                stop,
    input  logic [CNT_BITS-1:0] nticks,
    output logic                tick,
    output logic                busy,
    output logic                done,
    output logic [CNT_BITS-1:0] remaining
);

    chan_state_t state;

    // busy lags the final tick by one cycle so it drops together with done
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= start && !stop;
                    if (start && !stop) begin
                        state     <= RUN;
                        remaining <= nticks;
                    end
                end
                RUN: begin
                    busy <= !stop;
                    if (stop) begin
                        state <= IDLE;
                    end else if (hit) begin
                        tick <= 1'b1;
                        if (remaining == CNT_BITS'(1)) begin
                            done      <= 1'b1;
                            remaining <= '0;
                            state     <= IDLE;
                        end else if (remaining != '0) begin
                            remaining <= remaining - CNT_BITS'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tick_burst.sv
// Multi-channel burst tick generator fed by prescaler toggle outputs.
// Optional input synchronizer enabled by defining TICK_BURST_SYNC_EN.
module tick_burst
    import tick_burst_pkg::*;
#(
    parameter int unsigned SIZE     = 4,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SIZE-1:0]          f_in,
    input  logic [SIZE-1:0]          start,
    input  logic [SIZE-1:0]          stop,
    input  logic [CNT_BITS*SIZE-1:0] nticks,
    output logic [SIZE-1:0]          tick,
    output logic [SIZE-1:0]          busy,
    output logic [SIZE-1:0]          done,
    output logic [CNT_BITS*SIZE-1:0] remaining
);

    localparam int unsigned PRIME_W = 2;

    logic [SIZE-1:0]    f_s;
    logic [SIZE-1:0]    f_q;
    logic [SIZE-1:0]    hit;
    logic [PRIME_W-1:0] prime_cnt;
    logic               primed;

`ifdef TICK_BURST_SYNC_EN
    localparam int unsigned PRIME_CYCLES = SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0][SIZE-1:0] sync_q;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], f_in};
    end

    assign f_s = sync_q[SYNC_STAGES-1];
`else
    localparam int unsigned PRIME_CYCLES = 1;

    assign f_s = f_in;
`endif

    // history register reloads every cycle; edges are masked until it holds real data
    always_ff @(posedge clk) begin
        f_q <= f_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
        end
    end

    assign primed = (prime_cnt == PRIME_W'(PRIME_CYCLES));
    assign hit    = primed ? (f_s ^ f_q) : '0;

    for (genvar i = 0; i < SIZE; i++) begin : g_chan
        tick_burst_chan #(
            .CNT_BITS (CNT_BITS)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .hit       (hit[i]),
            .start     (start[i]),
            .stop      (stop[i]),
            .nticks    (nticks[CNT_BITS*i +: CNT_BITS]),
            .tick      (tick[i]),
            .busy      (busy[i]),
            .done      (done[i]),
            .remaining (remaining[CNT_BITS*i +: CNT_BITS])
        );
    end

endmodule

// File: tb/tb_tick_burst.sv
// Self-checking bench for tick_burst: directed scenarios plus random traffic vs a reference model.
module tb_tick_burst;

    localparam int SIZE = 4;
    localparam int CNT  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [SIZE-1:0]     f_in;
    logic [SIZE-1:0]     start;
    logic [SIZE-1:0]     stop;
    logic [CNT*SIZE-1:0] nticks;
    logic [SIZE-1:0]     tick;
    logic [SIZE-1:0]     busy;
    logic [SIZE-1:0]     done;
    logic [CNT*SIZE-1:0] remaining;

    tick_burst #(.SIZE(SIZE), .CNT_BITS(CNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_in      (f_in),
        .start     (start),
        .stop      (stop),
        .nticks    (nticks),
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle", tag, got, exp);
        end
    endtask

    // Reference model: burst bookkeeping per channel from the behavioural rules
`ifdef TICK_BURST_SYNC_EN
    localparam int PRIME = 3;
`else
    localparam int PRIME = 1;
`endif
    int              prime_left;
    logic [SIZE-1:0] f_prev, f_d1, f_d2, f_eff;
    bit              m_run [SIZE];
    logic [CNT-1:0]  m_rem [SIZE];
    logic [SIZE-1:0] exp_tick, exp_done, exp_busy;
    logic [63:0]     exp_rem;

    always @(posedge clk) begin
`ifdef TICK_BURST_SYNC_EN
        f_eff = f_d2;
        f_d2  = f_d1;
        f_d1  = f_in;
`else
        f_eff = f_in;
`endif
        if (rst) begin
            prime_left = PRIME;
            exp_tick   = '0;
            exp_done   = '0;
            exp_busy   = '0;
            for (int i = 0; i < SIZE; i++) begin
                m_run[i] = 1'b0;
                m_rem[i] = '0;
            end
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                bit ev;
                ev = (prime_left == 0) && (f_eff[i] != f_prev[i]);
                exp_tick[i] = 1'b0;
                exp_done[i] = 1'b0;
                if (!m_run[i]) begin
                    if (start[i] && !stop[i]) begin
                        m_run[i] = 1'b1;
                        m_rem[i] = nticks[CNT*i +: CNT];
                    end
                end else if (stop[i]) begin
                    m_run[i] = 1'b0;
                end else if (ev) begin
                    exp_tick[i] = 1'b1;
                    if (m_rem[i] == 1) begin
                        exp_done[i] = 1'b1;
                        m_rem[i]    = '0;
                        m_run[i]    = 1'b0;
                    end else if (m_rem[i] > 1) begin
                        m_rem[i] = m_rem[i] - 1'b1;
                    end
                end
                exp_busy[i] = m_run[i] || exp_done[i];
            end
            if (prime_left > 0) prime_left--;
        end
        f_prev = f_eff;
        for (int i = 0; i < SIZE; i++) exp_rem[CNT*i +: CNT] = m_rem[i];
    end

    int cyc = 0;
    int per [SIZE];
    int tick_cnt [SIZE];
    int done_cnt [SIZE];
    int last_tick0;
    bit spacing_on = 1'b0;

    task automatic clear_counts();
        for (int i = 0; i < SIZE; i++) begin
            tick_cnt[i] = 0;
            done_cnt[i] = 0;
        end
        last_tick0 = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check("tick", 64'(tick), 64'(exp_tick));
        check("done", 64'(done), 64'(exp_done));
        check("busy", 64'(busy), 64'(exp_busy));
        check("remaining", remaining, exp_rem);
        for (int i = 0; i < SIZE; i++) begin
            tick_cnt[i] += int'(tick[i]);
            done_cnt[i] += int'(done[i]);
        end
        if (spacing_on && tick[0]) begin
            if (last_tick0 >= 0) check("tick_spacing", 64'(cyc - last_tick0), 64'd3);
            last_tick0 = cyc;
        end
    endtask

    task automatic cycle();
        for (int i = 0; i < SIZE; i++)
            if (per[i] != 0 && (cyc % per[i]) == 0) f_in[i] = ~f_in[i];
        step();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic set_n(input int ch, input int v);
        nticks[CNT*ch +: CNT] = CNT'(v);
    endtask

    task automatic pulse_start(input logic [SIZE-1:0] m);
        start = m;
        cycle();
        start = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        bit found;
        rst    = 1'b1;
        f_in   = '0;
        start  = '0;
        stop   = '0;
        nticks = '0;
        for (int i = 0; i < SIZE; i++) per[i] = 0;
        clear_counts();
        run(3);
        check("rst_tick", 64'(tick), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_remaining", remaining, 64'd0);
        rst = 1'b0;
        run(2);

        // finite burst of 4 on a toggle every 3 cycles
        per[0] = 3;
        set_n(0, 4);
        clear_counts();
        spacing_on = 1'b1;
        pulse_start(4'b0001);
        run(25);
        spacing_on = 1'b0;
        check("burst_ticks", 64'(tick_cnt[0]), 64'd4);
        check("burst_done", 64'(done_cnt[0]), 64'd1);
        check("burst_busy_end", 64'(busy[0]), 64'd0);

        // free-run and abort after 10 ticks
        per[0] = 2;
        set_n(0, 0);
        clear_counts();
        pulse_start(4'b0001);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cycle();
            if (tick_cnt[0] == 10) found = 1'b1;
        end
        check("freerun_reached10", 64'(found), 64'd1);
        stop = 4'b0001;
        cycle();
        stop = '0;
        check("freerun_busy_stop", 64'(busy[0]), 64'd0);
        run(6);
        check("freerun_ticks", 64'(tick_cnt[0]), 64'd10);
        check("freerun_done", 64'(done_cnt[0]), 64'd0);
        check("freerun_remaining", 64'(remaining[CNT-1:0]), 64'd0);
        per[0] = 0;

        // start and stop together while idle
        per[1] = 1;
        clear_counts();
        start = 4'b0010;
        stop  = 4'b0010;
        cycle();
        start = '0;
        stop  = '0;
        run(5);
        check("collide_busy", 64'(busy[1]), 64'd0);
        check("collide_ticks", 64'(tick_cnt[1]), 64'd0);

        // start coincident with an edge: that edge is not counted
        set_n(1, 3);
        clear_counts();
        pulse_start(4'b0010);
        check("edge_start_busy", 64'(busy[1]), 64'd1);
        check("edge_start_ticks", 64'(tick_cnt[1]), 64'd0);
        run(6);
        check("edge_start_total", 64'(tick_cnt[1]), 64'd3);
        per[1] = 0;

        // restart while running is ignored
        set_n(2, 5);
        pulse_start(4'b0100);
        set_n(2, 9);
        pulse_start(4'b0100);
        run(2);
        check("restart_ignored", 64'(remaining[CNT*2 +: CNT]), 64'd5);
        stop = 4'b0100;
        cycle();
        stop = '0;
        check("restart_rem_hold", 64'(remaining[CNT*2 +: CNT]), 64'd5);

        // f_in high through reset yields no tick after release
        f_in = 4'b1111;
        rst  = 1'b1;
        run(2);
        rst = 1'b0;
        clear_counts();
        for (int i = 0; i < SIZE; i++) set_n(i, 0);
        pulse_start(4'b1111);
        run(5);
        check("prime_ticks", 64'(tick_cnt[0] + tick_cnt[1] + tick_cnt[2] + tick_cnt[3]), 64'd0);
        stop = 4'b1111;
        cycle();
        stop = '0;

        // reset mid-burst with 2 ticks remaining
        per[0] = 3;
        set_n(0, 4);
        clear_counts();
        pulse_start(4'b0001);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            cycle();
            if (remaining[CNT-1:0] == CNT'(2)) found = 1'b1;
        end
        check("midrst_reached2", 64'(found), 64'd1);
        rst = 1'b1;
        cycle();
        check("midrst_done", 64'(done_cnt[0]), 64'd0);
        check("midrst_outputs", {tick, busy, done, 52'd0} | remaining, 64'd0);
        rst = 1'b0;
        run(2);

        // independence: ch0 burst 2 on div 2, ch3 burst 7 on div 3
        per[0] = 2;
        per[3] = 3;
        set_n(0, 2);
        set_n(3, 7);
        clear_counts();
        pulse_start(4'b1001);
        run(40);
        check("indep_ticks0", 64'(tick_cnt[0]), 64'd2);
        check("indep_ticks3", 64'(tick_cnt[3]), 64'd7);
        check("indep_done0", 64'(done_cnt[0]), 64'd1);
        check("indep_done3", 64'(done_cnt[3]), 64'd1);
        check("indep_quiet12", 64'(tick_cnt[1] + tick_cnt[2]), 64'd0);

        // random traffic checked cycle by cycle against the model
        for (int i = 0; i < SIZE; i++) per[i] = int'($urandom_range(0, 4));
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < SIZE; i++) begin
                start[i] = ($urandom_range(0, 7) == 0);
                stop[i]  = ($urandom_range(0, 19) == 0);
                set_n(i, int'($urandom_range(0, 6)));
                if ($urandom_range(0, 199) == 0) per[i] = int'($urandom_range(0, 4));
            end
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        start = '0;
        stop  = '0;
        rst   = 1'b0;
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
